// File: rtl/fetch_prefetch_buffer_if.sv
// Bus bundle for the prefetch buffer: load_unit request/return, decode handshake and redirect.
// The slave modport is the prefetch buffer's view; master is the surrounding pipeline's view.
interface fetch_prefetch_buffer_if;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        read_o;
  logic [31:0] addr_o;
  logic        valid_i;
  logic [31:0] data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  modport slave (
    input  flush_i, flush_pc_i, valid_i, data_i, instr_ready_i,
    output read_o, addr_o, instr_valid_o, instr_o, instr_pc_o
  );

  modport master (
    output flush_i, flush_pc_i, valid_i, data_i, instr_ready_i,
    input  read_o, addr_o, instr_valid_o, instr_o, instr_pc_o
  );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch stage: requests sequential words from load_unit, buffers {pc, word}
// in a small FIFO for decode, and restarts the stream at a new PC on a redirect.
module fetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                   clk,
  input logic                   rst_i,
  fetch_prefetch_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {FETCH, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     mem_data_q [DEPTH];
  logic [31:0]     mem_pc_q   [DEPTH];
  logic [31:0]     flush_target;

  logic read;
  logic instr_valid;
  logic push;
  logic pop;

  // Returns are only accepted while requesting, so full/flush/FLUSH-state returns drop out here.
  assign read        = (state_q == FETCH) && !bus.flush_i && !rst_i && (count_q < FULL);
  assign instr_valid = (count_q != '0) && !bus.flush_i;
  assign push        = read && bus.valid_i;
  assign pop         = instr_valid && bus.instr_ready_i;

  assign flush_target = bus.flush_pc_i & ~32'h0000_0003;

  assign bus.read_o        = read;
  assign bus.addr_o        = pc_q;
  assign bus.instr_valid_o = instr_valid;
  assign bus.instr_o       = mem_data_q[rd_ptr_q];
  assign bus.instr_pc_o    = mem_pc_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush_i) begin
      state_d  = FLUSH;
      pc_d     = flush_target;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      state_d = FETCH;
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only observed while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= bus.data_i;
      mem_pc_q[wr_ptr_q]   <= pc_q;
    end
  end

endmodule
